// File: rtl/draw_pkg.sv
// Shared types for the draw sequencer: FSM state encoding, command op codes
// and the status word reported to software.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLANK,
        CLEAR,
        DRAW,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] OP_CLEAR      = 2'b00;
    localparam logic [1:0] OP_DRAW       = 2'b01;
    localparam logic [1:0] OP_CLEAR_DRAW = 2'b10;
    localparam logic [1:0] OP_RSVD       = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    function automatic logic [1:0] status_of(input state_t s);
        logic [1:0] st;
        case (s)
            IDLE:                    st = ST_IDLE;
            WAIT_BLANK, CLEAR, DRAW: st = ST_BUSY;
            DONE:                    st = ST_DONE;
            default:                 st = ST_ERR;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/draw_timeout_ctr.sv
// Per-phase watchdog for the draw sequencer: counts engine cycles since the
// last engine start and flags the phase as hung.
module draw_timeout_ctr #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Raised in the cycle whose increment lands on TIMEOUT_CYCLES-1, so the
    // sequencer enters ERROR on the same edge the count reaches that value.
    assign expired = en && (cnt_q == (TIMEOUT_CYCLES - 24'd2));

endmodule

// File: rtl/draw_sequencer.sv
// Command sequencer between the processor PIO and the drawing engine.
// Optional per-phase watchdog enabled by defining DRAW_SEQ_TIMEOUT_EN.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
    parameter bit          BLANK_SYNC     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic       vblank,
    output logic       eng_start,
    output logic       eng_op,
    input  logic       eng_done,
    output logic [1:0] status
);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [1:0] status_q, status_d;
    logic       eng_start_q, eng_start_d;
    logic       eng_op_q, eng_op_d;
    logic       phase_done;
    logic       timeout_hit;

    // The engine cannot finish in its own start cycle, so ignore done there.
    assign phase_done = eng_done && !eng_start_q;

`ifdef DRAW_SEQ_TIMEOUT_EN
    draw_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (eng_start_d),
        .en     ((state_q == CLEAR) || (state_q == DRAW)),
        .expired(timeout_hit)
    );
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_CLEAR;
            status_q    <= ST_IDLE;
            eng_start_q <= 1'b0;
            eng_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            status_q    <= status_d;
            eng_start_q <= eng_start_d;
            eng_op_q    <= eng_op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_op == OP_RSVD) ? ERROR : WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                if (!cmd_valid) begin
                    state_d = IDLE;
                end else if (vblank || !BLANK_SYNC) begin
                    state_d = (op_q == OP_DRAW) ? DRAW : CLEAR;
                end
            end
            CLEAR: begin
                if (phase_done) begin
                    state_d = (op_q == OP_CLEAR_DRAW) ? DRAW : DONE;
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            DRAW: begin
                if (phase_done) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            DONE, ERROR: begin
                if (!cmd_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d = op_q;
        if ((state_q == IDLE) && (state_d == WAIT_BLANK)) begin
            op_d = cmd_op;
        end
        eng_start_d = ((state_d == CLEAR) || (state_d == DRAW)) && (state_d != state_q);
        eng_op_d    = eng_op_q;
        if (eng_start_d) begin
            eng_op_d = (state_d == DRAW);
        end
        status_d = status_of(state_q);
    end

    assign eng_start = eng_start_q;
    assign eng_op    = eng_op_q;
    assign status    = status_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a queue-based reference model
// compared against the DUT outputs on every falling clock edge.
module tb_draw_sequencer;

    localparam int T = 16;
`ifdef DRAW_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       vblank;
    logic       eng_start;
    logic       eng_op;
    logic       eng_done;
    logic [1:0] status;

    int tests = 0;
    int failed = 0;
    int start_seen = 0;

    draw_sequencer #(
        .TIMEOUT_CYCLES(24'd16),
        .BLANK_SYNC    (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .vblank   (vblank),
        .eng_start(eng_start),
        .eng_op   (eng_op),
        .eng_done (eng_done),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: a command becomes a list of engine phases that are
    // consumed one per completion pulse; status reports last cycle's activity.
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_DONE, M_ERR} mmode_t;
    mmode_t     mode = M_IDLE;
    int         phases[$];
    logic       m_start = 1'b0;
    logic       m_op = 1'b0;
    logic [1:0] m_status = 2'd0;
    int         rc = 0;

    always @(posedge clk or posedge reset) begin
        mmode_t prev;
        logic   s_n;
        if (reset) begin
            mode = M_IDLE;
            phases.delete();
            m_start = 1'b0;
            m_op = 1'b0;
            m_status = 2'd0;
            rc = 0;
        end else begin
            prev = mode;
            s_n = 1'b0;
            case (mode)
                M_IDLE: if (cmd_valid) begin
                    if (cmd_op == 2'd3) mode = M_ERR;
                    else begin
                        phases.delete();
                        if (cmd_op != 2'd1) phases.push_back(0);
                        if (cmd_op != 2'd0) phases.push_back(1);
                        mode = M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (!cmd_valid) mode = M_IDLE;
                    else if (vblank) begin
                        mode = M_RUN;
                        s_n = 1'b1;
                    end
                end
                M_RUN: begin
                    if (eng_done && !m_start) begin
                        void'(phases.pop_front());
                        if (phases.size() == 0) mode = M_DONE;
                        else s_n = 1'b1;
                    end else if (TMO_EN) begin
                        rc++;
                        if (rc == T - 1) mode = M_ERR;
                    end
                end
                default: if (!cmd_valid) mode = M_IDLE;
            endcase
            if (s_n) begin
                rc = 0;
                m_op = (phases[0] == 1);
            end
            m_start = s_n;
            m_status = (prev == M_IDLE) ? 2'd0 :
                       (prev == M_DONE) ? 2'd2 :
                       (prev == M_ERR)  ? 2'd3 : 2'd1;
        end
    end

    always @(negedge clk) begin
        chk("model_eng_start", eng_start, m_start);
        chk("model_eng_op", eng_op, m_op);
        chk("model_status", status, m_status);
        if (eng_start === 1'b1) start_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        vblank = 1'b0;
        eng_done = 1'b0;
        cyc(2);
        chk("reset_status", status, 2'd0);
        chk("reset_eng_start", eng_start, 1'b0);
        chk("reset_eng_op", eng_op, 1'b0);
        reset = 1'b0;
        cyc(2);

        // DRAW only, blanking arrives after 10 cycles
        cmd_op = 2'd1;
        cmd_valid = 1'b1;
        cyc(10);
        chk("wait_no_start", eng_start, 1'b0);
        chk("wait_status", status, 2'd1);
        vblank = 1'b1;
        cyc(1);
        chk("draw_start", eng_start, 1'b1);
        chk("draw_op", eng_op, 1'b1);
        cyc(1);
        chk("draw_start_single", eng_start, 1'b0);
        vblank = 1'b0;
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        cyc(1);
        chk("draw_done_status", status, 2'd2);
        cmd_valid = 1'b0;
        cyc(2);
        chk("draw_idle_status", status, 2'd0);

        // CLEAR then DRAW
        cmd_op = 2'd2;
        vblank = 1'b1;
        cmd_valid = 1'b1;
        cyc(2);
        chk("cd_clear_start", eng_start, 1'b1);
        chk("cd_clear_op", eng_op, 1'b0);
        cyc(3);
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        chk("cd_draw_start", eng_start, 1'b1);
        chk("cd_draw_op", eng_op, 1'b1);
        cyc(4);
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        cyc(1);
        chk("cd_done_status", status, 2'd2);

        // held request must not retrigger
        n0 = start_seen;
        repeat (100) begin
            vblank = ~vblank;
            cyc(1);
        end
        chk("held_no_retrigger", start_seen - n0, 0);
        chk("held_status", status, 2'd2);
        cmd_valid = 1'b0;
        cyc(2);
        chk("held_release_status", status, 2'd0);
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        cyc(2);
        chk("spurious_done_status", status, 2'd0);
        chk("spurious_done_start", eng_start, 1'b0);

        // reserved op
        n0 = start_seen;
        cmd_op = 2'd3;
        cmd_valid = 1'b1;
        cyc(1);
        chk("rsvd_status_c1", status, 2'd0);
        cyc(1);
        chk("rsvd_status_c2", status, 2'd3);
        cyc(5);
        chk("rsvd_no_start", start_seen - n0, 0);
        cmd_valid = 1'b0;
        cyc(2);
        chk("rsvd_release_status", status, 2'd0);

        // request withdrawn while waiting for blanking
        vblank = 1'b0;
        cmd_op = 2'd0;
        cmd_valid = 1'b1;
        cyc(3);
        cmd_valid = 1'b0;
        n0 = start_seen;
        cyc(2);
        vblank = 1'b1;
        cyc(4);
        chk("abort_wait_no_start", start_seen - n0, 0);
        chk("abort_wait_status", status, 2'd0);

        // request withdrawn during CLEAR does not abort it
        cmd_valid = 1'b1;
        cyc(2);
        chk("clr_start", eng_start, 1'b1);
        chk("clr_op", eng_op, 1'b0);
        cmd_valid = 1'b0;
        cyc(4);
        chk("clr_drop_busy", status, 2'd1);
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        cyc(1);
        chk("clr_drop_done", status, 2'd2);
        cyc(1);
        chk("clr_drop_idle", status, 2'd0);

        // engine never finishes
        cmd_op = 2'd1;
        cmd_valid = 1'b1;
        cyc(2);
        chk("tmo_start", eng_start, 1'b1);
        cyc(15);
        chk("tmo_s15_status", status, 2'd1);
        cyc(1);
        chk("tmo_s16_status", status, TMO_EN ? 2'd3 : 2'd1);
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        cmd_valid = 1'b0;
        cyc(3);
        chk("tmo_release_status", status, 2'd0);

        // reset in the middle of a DRAW phase
        cmd_op = 2'd1;
        cmd_valid = 1'b1;
        cyc(2);
        chk("rst_pre_start", eng_start, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_start", eng_start, 1'b0);
        chk("rst_async_status", status, 2'd0);
        cmd_valid = 1'b0;
        cyc(1);
        reset = 1'b0;
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        cyc(2);
        chk("rst_late_done_status", status, 2'd0);
        chk("rst_late_done_start", eng_start, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd2_000_000: maximum engine cycles allowed per phase before the block declares an error.
REQ-003 Parameter BLANK_SYNC, default 1: when 1, a command starts only during vertical blanking; when 0, it starts immediately.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port cmd_valid, input, 1: software request level, driven from the processor output PIO.
REQ-007 Port cmd_op, input, 2: operation code. 00 = CLEAR; 01 = DRAW; 10 = CLEAR then DRAW; 11 = reserved.
REQ-008 Port vblank, input, 1: vertical-blanking level from the VGA timing block.
REQ-009 Port eng_start, output, 1: one-cycle start pulse to the drawing engine.
REQ-010 Port eng_op, output, 1: engine operation for the current phase. 0 = clear; 1 = draw.
REQ-011 Port eng_done, input, 1: one-cycle completion pulse from the engine.
REQ-012 Port status, output, 2: status word to the drawing_status input PIO. 00 = IDLE; 01 = BUSY; 10 = DONE; 11 = ERROR.

Function
REQ-013 States SHALL be IDLE, WAIT_BLANK, CLEAR, DRAW, DONE and ERROR.
REQ-014 IDLE: on cmd_valid=1 with cmd_op≠11, latch cmd_op and go to WAIT_BLANK; on cmd_valid=1 with cmd_op=11, go to ERROR.
REQ-015 WAIT_BLANK: start the first phase in the cycle where vblank=1, or in the next cycle when BLANK_SYNC=0.
- The first phase is CLEAR for ops 00 and 10, and DRAW for op 01.
REQ-016 Phase start: eng_start is high for exactly the first cycle of CLEAR or DRAW; eng_op is held stable for the whole phase.
REQ-017 CLEAR: on eng_done, go to DRAW if the latched op is 10, otherwise go to DONE.
- A CLEAR→DRAW transition issues a fresh eng_start one cycle after eng_done, with no wait for blanking.
REQ-018 DRAW: on eng_done, go to DONE.
REQ-019 status SHALL be registered and change one cycle after the state change.
- IDLE → 00; WAIT_BLANK, CLEAR and DRAW → 01; DONE → 10; ERROR → 11.
REQ-020 DONE and ERROR SHALL hold until cmd_valid=0 (four-phase handshake), then return to IDLE.
REQ-021 A level held on cmd_valid SHALL never retrigger a command; a new command requires a 0→1 re-handshake through IDLE.
REQ-022 eng_done while in IDLE, WAIT_BLANK, DONE or ERROR SHALL be ignored.
REQ-023 cmd_valid dropping during WAIT_BLANK SHALL return the block to IDLE with no engine start.
- cmd_valid dropping during CLEAR or DRAW SHALL NOT abort the phase.
REQ-024 eng_start and eng_done in the same cycle cannot occur; eng_done is sampled only from the cycle after eng_start onward.

Reset
REQ-025 Reset SHALL force: state=IDLE, status=00, eng_start=0, eng_op=0, latched op=00, timeout counter=0.
REQ-026 Reset mid-phase SHALL drop eng_start immediately; any later eng_done is ignored per REQ-022.

Configuration
REQ-027 With DRAW_SEQ_TIMEOUT_EN defined, a 24-bit counter SHALL run as follows:
- clears on each eng_start;
- increments every cycle in CLEAR or DRAW;
- on reaching TIMEOUT_CYCLES-1 without eng_done, forces ERROR.
REQ-028 Without DRAW_SEQ_TIMEOUT_EN, the counter SHALL not exist, and CLEAR and DRAW wait for eng_done indefinitely.

Structure
REQ-029 Package draw_pkg SHALL hold:
- the state enum;
- op codes OP_CLEAR, OP_DRAW, OP_CLEAR_DRAW, OP_RSVD;
- status codes ST_IDLE, ST_BUSY, ST_DONE, ST_ERR.
REQ-030 Sub-module draw_timeout_ctr SHALL hold the timeout counter, instantiated only under DRAW_SEQ_TIMEOUT_EN.
- Ports: clk, reset, clr, en, expired.

Verification
REQ-031 op=01, vblank=0 for 10 cycles then 1 → eng_start on the first vblank cycle with eng_op=1; status 01; eng_done → status 10; cmd_valid=0 → status 00.
REQ-032 op=10, BLANK_SYNC=1 → CLEAR start with eng_op=0; eng_done → DRAW eng_start exactly 1 cycle later with eng_op=1; second eng_done → status 10.
REQ-033 op=11 → status 11 two cycles after cmd_valid, no eng_start; cmd_valid=0 → status 00.
REQ-034 cmd_valid held high after DONE for 100 cycles → no second eng_start; spurious eng_done in IDLE → no state change.
REQ-035 Timeout test, DRAW_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, eng_done withheld → status 11 at 16 cycles after eng_start; undefined → status stays 01.
REQ-036 Reset asserted mid-DRAW → status 00 and eng_start 0 asynchronously; a later eng_done is ignored.
